// File: rtl/ingress_scheduler_pkg.sv
// Shared definitions for the ingress scheduler slice.
// Holds the FSM state encoding, the class count, the class ID width and the
// nibble width. It also provides a helper for the round-robin index wrap.
package ingress_scheduler_pkg;

  localparam int NUM_CLASSES = 4;
  localparam int ID_W        = 2;
  localparam int DATA_W      = 4;

  typedef enum logic [1:0] {
    WAIT_INIT = 2'd0,
    ACTIVE    = 2'd1,
    HALT      = 2'd2
  } state_e;

  // Class index 'off' positions after 'base', wrapping modulo NUM_CLASSES.
  function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base,
                                               input logic [ID_W:0]   off);
    logic [ID_W:0] sum;
    sum = {1'b0, base} + off;
    return sum[ID_W-1:0];
  endfunction

endpackage

// File: rtl/class_buffer.sv
// Per-class holding FIFO for data nibbles.
// Ports:
//   clk_i, rst_ni    clock, async active-low reset (empties the FIFO)
//   wr_en_i/wr_data  enqueue one nibble (ignored when full)
//   rd_en_i          dequeue the head entry (ignored when empty)
//   rd_data_o        current head entry
//   full_o, empty_o  occupancy flags, derived from registered pointers only
module class_buffer
  import ingress_scheduler_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]       wr_ptr_q, rd_ptr_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en_i && !full_o)  wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (rd_en_i && !empty_o) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i && !full_o) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/ingress_scheduler.sv
// Four-class ingress scheduler: buffers per-class nibbles, arbitrates them
// round-robin into a downstream layer and honours pause/continue/error
// flow control from that layer.
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   src_valid_i, src_data0..3_i   per-class source requests and nibbles
//   src_ready_o                   per-class acceptance
//   idle_i                        downstream layer ready for traffic
//   pause/continue_stb_i          per-class flow-control strobes
//   error_full_i                  per-class downstream overflow
//   pushdatoentrada_o, idinput_o, dato_in_o   registered push interface
//   paused_o, halted_o            flow-control status
//   sent_cnt0..3_o                per-class push counters (wrapping)
module ingress_scheduler
  import ingress_scheduler_pkg::*;
#(
  parameter int BUF_DEPTH = 2,
  parameter int CNT_W     = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_CLASSES-1:0] src_valid_i,
  input  logic [DATA_W-1:0]      src_data0_i,
  input  logic [DATA_W-1:0]      src_data1_i,
  input  logic [DATA_W-1:0]      src_data2_i,
  input  logic [DATA_W-1:0]      src_data3_i,
  output logic [NUM_CLASSES-1:0] src_ready_o,
  input  logic                   idle_i,
  input  logic [NUM_CLASSES-1:0] pause_stb_i,
  input  logic [NUM_CLASSES-1:0] continue_stb_i,
  input  logic [NUM_CLASSES-1:0] error_full_i,
  output logic                   pushdatoentrada_o,
  output logic [ID_W-1:0]        idinput_o,
  output logic [DATA_W-1:0]      dato_in_o,
  output logic [NUM_CLASSES-1:0] paused_o,
  output logic                   halted_o,
  output logic [CNT_W-1:0]       sent_cnt0_o,
  output logic [CNT_W-1:0]       sent_cnt1_o,
  output logic [CNT_W-1:0]       sent_cnt2_o,
  output logic [CNT_W-1:0]       sent_cnt3_o
);

  state_e                 state_q;
  logic                   halted_q;
  logic [NUM_CLASSES-1:0] paused_q, paused_d;
  logic [ID_W-1:0]        rr_ptr_q;
  logic                   push_q;
  logic [ID_W-1:0]        id_q;
  logic [DATA_W-1:0]      dato_q;
  logic [CNT_W-1:0]       cnt_q [NUM_CLASSES];

  logic [DATA_W-1:0]      src_data [NUM_CLASSES];
  logic [DATA_W-1:0]      buf_data [NUM_CLASSES];
  logic [NUM_CLASSES-1:0] buf_full, buf_empty, accept, eligible, rd_en;
  logic                   grant_vld;
  logic [ID_W-1:0]        grant_id;

  assign src_data[0] = src_data0_i;
  assign src_data[1] = src_data1_i;
  assign src_data[2] = src_data2_i;
  assign src_data[3] = src_data3_i;

  // Ready looks only at registered occupancy, so a same-cycle dequeue never
  // opens room for an accept into a full buffer.
  assign src_ready_o = ~buf_full & {NUM_CLASSES{state_q != WAIT_INIT}};
  assign accept      = src_valid_i & src_ready_o;

  // A pause strobe blocks its class in the very cycle it arrives.
  assign eligible = ~buf_empty & ~paused_q & ~pause_stb_i &
                    {NUM_CLASSES{state_q == ACTIVE}};

  assign paused_d = pause_stb_i | (paused_q & ~continue_stb_i);

  for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_buf
    class_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .wr_en_i   (accept[g]),
      .wr_data_i (src_data[g]),
      .rd_en_i   (rd_en[g]),
      .rd_data_o (buf_data[g]),
      .full_o    (buf_full[g]),
      .empty_o   (buf_empty[g])
    );
  end

  // Scan from farthest to nearest so the class right after the pointer wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    rd_en     = '0;
    for (int k = NUM_CLASSES; k >= 1; k--) begin
      if (eligible[rr_index(rr_ptr_q, (ID_W+1)'(k))]) begin
        grant_vld = 1'b1;
        grant_id  = rr_index(rr_ptr_q, (ID_W+1)'(k));
      end
    end
    if (grant_vld) rd_en[grant_id] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= WAIT_INIT;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        WAIT_INIT: if (idle_i) state_q <= ACTIVE;
        ACTIVE: if (|error_full_i) begin
          state_q  <= HALT;
          halted_q <= 1'b1;
        end
        HALT: if ((|continue_stb_i) && !(|error_full_i)) begin
          state_q  <= ACTIVE;
          halted_q <= 1'b0;
        end
        default: begin
          state_q  <= WAIT_INIT;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      push_q   <= 1'b0;
      id_q     <= '0;
      dato_q   <= '0;
      rr_ptr_q <= ID_W'(NUM_CLASSES - 1);
      paused_q <= '0;
      for (int i = 0; i < NUM_CLASSES; i++) cnt_q[i] <= '0;
    end else begin
      paused_q <= paused_d;
      push_q   <= grant_vld;
      if (grant_vld) begin
        id_q            <= grant_id;
        dato_q          <= buf_data[grant_id];
        rr_ptr_q        <= grant_id;
        cnt_q[grant_id] <= cnt_q[grant_id] + CNT_W'(1);
      end
    end
  end

  assign pushdatoentrada_o = push_q;
  assign idinput_o         = id_q;
  assign dato_in_o         = dato_q;
  assign paused_o          = paused_q;
  assign halted_o          = halted_q;
  assign sent_cnt0_o       = cnt_q[0];
  assign sent_cnt1_o       = cnt_q[1];
  assign sent_cnt2_o       = cnt_q[2];
  assign sent_cnt3_o       = cnt_q[3];

endmodule

// File: tb/tb_ingress_scheduler.sv
module tb_ingress_scheduler;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  valid = '0, pause = '0, cont = '0, err = '0;
  logic        idle = 1'b0;
  logic [15:0] data_bus = '0;
  logic [3:0]  ready, paused, dat;
  logic        push, halted;
  logic [1:0]  id;
  logic [7:0]  cnt0, cnt1, cnt2, cnt3;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ingress_scheduler #(.BUF_DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .src_valid_i       (valid),
    .src_data0_i       (data_bus[3:0]),
    .src_data1_i       (data_bus[7:4]),
    .src_data2_i       (data_bus[11:8]),
    .src_data3_i       (data_bus[15:12]),
    .src_ready_o       (ready),
    .idle_i            (idle),
    .pause_stb_i       (pause),
    .continue_stb_i    (cont),
    .error_full_i      (err),
    .pushdatoentrada_o (push),
    .idinput_o         (id),
    .dato_in_o         (dat),
    .paused_o          (paused),
    .halted_o          (halted),
    .sent_cnt0_o       (cnt0),
    .sent_cnt1_o       (cnt1),
    .sent_cnt2_o       (cnt2),
    .sent_cnt3_o       (cnt3)
  );

  // Reference model: queues per class plus flow-control and counter state.
  logic [3:0] mq [4][$];
  int         m_state;     // 0 waiting for init, 1 running, 2 halted
  logic [3:0] m_paused;
  int         m_rr;
  int         m_cnt [4];
  logic       m_push;
  logic [1:0] m_id;
  logic [3:0] m_dat;

  task automatic m_reset();
    for (int i = 0; i < 4; i++) begin
      mq[i].delete();
      m_cnt[i] = 0;
    end
    m_state = 0; m_paused = '0; m_rr = 3;
    m_push = 1'b0; m_id = '0; m_dat = '0;
  endtask

  function automatic logic [3:0] m_ready();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (mq[i].size() < DEPTH) && (m_state != 0);
    return r;
  endfunction

  task automatic m_step();
    logic [3:0] rdy;
    int g;
    rdy = m_ready();
    g = -1;
    if (m_state == 1) begin
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (m_rr + k) % 4;
        if (g < 0 && mq[c].size() > 0 && !m_paused[c] && !pause[c]) g = c;
      end
    end
    m_push = (g >= 0);
    if (g >= 0) begin
      m_id = 2'(g);
      m_dat = mq[g].pop_front();
      m_cnt[g] = (m_cnt[g] + 1) % 256;
      m_rr = g;
    end
    for (int i = 0; i < 4; i++)
      if (valid[i] && rdy[i]) mq[i].push_back(data_bus[4*i +: 4]);
    m_paused = pause | (m_paused & ~cont);
    case (m_state)
      0: if (idle) m_state = 1;
      1: if (|err) m_state = 2;
      default: if ((|cont) && !(|err)) m_state = 1;
    endcase
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [3:0] er;
    er = m_ready();
    vectors++;
    if (push !== m_push || id !== m_id || dat !== m_dat || ready !== er ||
        paused !== m_paused || halted !== (m_state == 2) ||
        cnt0 !== 8'(m_cnt[0]) || cnt1 !== 8'(m_cnt[1]) ||
        cnt2 !== 8'(m_cnt[2]) || cnt3 !== 8'(m_cnt[3])) begin
      miscompares++;
      $display("FAIL model %s t=%0t: push %b/%b id %0d/%0d dat %h/%h rdy %h/%h paused %h/%h halted %b/%b cnt %0d %0d %0d %0d / %0d %0d %0d %0d (got/exp)",
               tag, $time, push, m_push, id, m_id, dat, m_dat, ready, er, paused, m_paused,
               halted, (m_state == 2), cnt0, cnt1, cnt2, cnt3, m_cnt[0], m_cnt[1], m_cnt[2], m_cnt[3]);
    end
  endtask

  task automatic cyc(input string tag, input logic [3:0] v, input logic [15:0] db,
                     input logic idl, input logic [3:0] p, input logic [3:0] c,
                     input logic [3:0] e);
    @(negedge clk);
    valid = v; data_bus = db; idle = idl; pause = p; cont = c; err = e;
    m_step();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    valid = '0; data_bus = '0; idle = 1'b0; pause = '0; cont = '0; err = '0;
    m_reset();
    #2;
    chk("rst_push", push, 0);
    chk("rst_ready", ready, 0);
    chk("rst_halted", halted, 0);
    chk("rst_paused", paused, 0);
    chk("rst_id_dat", {id, dat}, 0);
    chk("rst_cnt", {cnt0, cnt1, cnt2, cnt3}, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0]  v;
    logic [15:0] db;
    logic        idl;
    logic        push;
    logic [1:0]  id;
    logic [3:0]  dat;
    logic [3:0]  rdy;
    logic [7:0]  c0;
  } vec_t;

  vec_t tbl [9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ids [$];
    int dats [$];
    int when [$];
    int n0, n1;

    tbl[0] = '{4'h0, 16'h0000, 1'b0, 1'b0, 2'd0, 4'h0, 4'h0, 8'd0};
    tbl[1] = '{4'h0, 16'h0000, 1'b1, 1'b0, 2'd0, 4'h0, 4'hF, 8'd0};
    tbl[2] = '{4'h1, 16'h000A, 1'b1, 1'b0, 2'd0, 4'h0, 4'hF, 8'd0};
    tbl[3] = '{4'h0, 16'h0000, 1'b1, 1'b1, 2'd0, 4'hA, 4'hF, 8'd1};
    tbl[4] = '{4'h0, 16'h0000, 1'b1, 1'b0, 2'd0, 4'hA, 4'hF, 8'd1};
    tbl[5] = '{4'h6, 16'h0530, 1'b1, 1'b0, 2'd0, 4'hA, 4'hF, 8'd1};
    tbl[6] = '{4'h0, 16'h0000, 1'b1, 1'b1, 2'd1, 4'h3, 4'hF, 8'd1};
    tbl[7] = '{4'h0, 16'h0000, 1'b1, 1'b1, 2'd2, 4'h5, 4'hF, 8'd1};
    tbl[8] = '{4'h0, 16'h0000, 1'b1, 1'b0, 2'd2, 4'h5, 4'hF, 8'd1};

    m_reset();
    do_reset();

    // Basic path: accept in N, push in N+2, then round-robin of two classes.
    foreach (tbl[i]) begin
      cyc("tbl", tbl[i].v, tbl[i].db, tbl[i].idl, 4'h0, 4'h0, 4'h0);
      vectors++;
      if (push !== tbl[i].push || id !== tbl[i].id || dat !== tbl[i].dat ||
          ready !== tbl[i].rdy || cnt0 !== tbl[i].c0) begin
        miscompares++;
        $display("FAIL vec %0d: push %b id %0d dat %h rdy %h cnt0 %0d, required %b %0d %h %h %0d",
                 i, push, id, dat, ready, cnt0, tbl[i].push, tbl[i].id, tbl[i].dat,
                 tbl[i].rdy, tbl[i].c0);
      end
    end

    // Fill all classes while halted, then release: strict 0,1,2,3,0,1,2,3.
    do_reset();
    cyc("ord_init", 4'h0, 16'h0, 1'b1, 4'h0, 4'h0, 4'h0);
    cyc("ord_err", 4'h0, 16'h0, 1'b1, 4'h0, 4'h0, 4'h8);
    chk("halt_after_err", halted, 1);
    cyc("ord_fill1", 4'hF, 16'h3210, 1'b1, 4'h0, 4'h0, 4'h0);
    cyc("ord_fill2", 4'hF, 16'h7654, 1'b1, 4'h0, 4'h0, 4'h0);
    chk("halt_no_push", push, 0);
    chk("full_ready", ready, 0);
    cyc("ord_cont", 4'h0, 16'h0, 1'b1, 4'h0, 4'h1, 4'h0);
    chk("cont_unhalt", halted, 0);
    for (int t = 0; t < 10; t++) begin
      cyc("ord_drain", 4'h0, 16'h0, 1'b1, 4'h0, 4'h0, 4'h0);
      if (push) begin
        ids.push_back(int'(id));
        dats.push_back(int'(dat));
        when.push_back(t);
      end
    end
    chk("ord_count", ids.size(), 8);
    for (int j = 0; j < 8 && j < ids.size(); j++) begin
      chk("ord_id", ids[j], j % 4);
      chk("ord_dat", dats[j], j);
      chk("ord_consec", when[j], when[0] + j);
    end

    // Pause and continue on class 1 in the same cycle: pause wins.
    cyc("p_err", 4'h0, 16'h0, 1'b1, 4'h0, 4'h0, 4'h1);
    cyc("p_fill1", 4'h3, 16'h00DC, 1'b1, 4'h0, 4'h0, 4'h0);
    cyc("p_fill2", 4'h3, 16'h00EF, 1'b1, 4'h0, 4'h0, 4'h0);
    cyc("p_both", 4'h0, 16'h0, 1'b1, 4'h2, 4'h2, 4'h0);
    chk("pause_wins", paused[1], 1);
    n0 = 0; n1 = 0;
    for (int t = 0; t < 4; t++) begin
      cyc("p_hold", 4'h0, 16'h0, 1'b1, 4'h0, 4'h0, 4'h0);
      if (push && id == 2'd0) n0++;
      if (push && id == 2'd1) n1++;
    end
    chk("paused_c1_pushes", n1, 0);
    chk("unpaused_c0_pushes", n0, 2);
    cyc("p_cont", 4'h0, 16'h0, 1'b1, 4'h0, 4'h2, 4'h0);
    chk("cont_clears", paused[1], 0);
    n1 = 0;
    for (int t = 0; t < 4; t++) begin
      cyc("p_resume", 4'h0, 16'h0, 1'b1, 4'h0, 4'h0, 4'h0);
      if (push && id == 2'd1) n1++;
    end
    chk("resumed_c1_pushes", n1, 2);
    cyc("p_one", 4'h2, 16'h0090, 1'b1, 4'h0, 4'h0, 4'h0);
    cyc("p_same_cycle", 4'h0, 16'h0, 1'b1, 4'h2, 4'h0, 4'h0);
    chk("pause_blocks_now", push, 0);
    cyc("p_release", 4'h0, 16'h0, 1'b1, 4'h0, 4'h2, 4'h0);
    cyc("p_release2", 4'h0, 16'h0, 1'b1, 4'h0, 4'h0, 4'h0);
    chk("p_release_push", {push, id, dat}, {1'b1, 2'd1, 4'h9});

    // Class 2: nothing accepted before init, then fill to full while paused.
    do_reset();
    for (int t = 0; t < 3; t++) begin
      cyc("w_feed", 4'h4, 16'h0700, 1'b0, 4'h0, 4'h0, 4'h0);
      chk("w_ready2", ready[2], 0);
    end
    cyc("w_init", 4'h0, 16'h0, 1'b1, 4'h4, 4'h0, 4'h0);
    chk("w_ready2_active", ready[2], 1);
    cyc("w_acc1", 4'h4, 16'h0100, 1'b1, 4'h0, 4'h0, 4'h0);
    cyc("w_acc2", 4'h4, 16'h0200, 1'b1, 4'h0, 4'h0, 4'h0);
    chk("w_full", ready[2], 0);
    cyc("w_blocked", 4'h4, 16'h0300, 1'b1, 4'h0, 4'h0, 4'h0);
    chk("w_still_full", ready[2], 0);
    cyc("w_cont", 4'h0, 16'h0, 1'b1, 4'h0, 4'h4, 4'h0);
    cyc("w_d1", 4'h0, 16'h0, 1'b1, 4'h0, 4'h0, 4'h0);
    chk("w_first", {push, id, dat}, {1'b1, 2'd2, 4'h1});
    cyc("w_d2", 4'h0, 16'h0, 1'b1, 4'h0, 4'h0, 4'h0);
    chk("w_second", {push, id, dat}, {1'b1, 2'd2, 4'h2});
    cyc("w_d3", 4'h0, 16'h0, 1'b1, 4'h0, 4'h0, 4'h0);
    chk("w_no_third", push, 0);

    // Counter wrap on class 0, then reset in the middle of the stream.
    do_reset();
    cyc("c_init", 4'h0, 16'h0, 1'b1, 4'h0, 4'h0, 4'h0);
    for (int t = 0; t < 400 && m_cnt[0] != 255; t++)
      cyc("c_stream", 4'h1, 16'($urandom), 1'b1, 4'h0, 4'h0, 4'h0);
    chk("cnt_255", cnt0, 255);
    for (int t = 0; t < 10 && m_cnt[0] != 0; t++)
      cyc("c_stream", 4'h1, 16'($urandom), 1'b1, 4'h0, 4'h0, 4'h0);
    chk("cnt_wrap", cnt0, 0);
    chk("mid_push_before", push, 1);
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("mid_rst_push", push, 0);
    chk("mid_rst_ready", ready, 0);
    valid = '0; idle = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc("m_init", 4'h0, 16'h0, 1'b1, 4'h0, 4'h0, 4'h0);
    chk("mid_empty_ready", ready, 15);
    cyc("m_idle", 4'h0, 16'h0, 1'b1, 4'h0, 4'h0, 4'h0);
    chk("mid_empty_nopush", push, 0);

    // Random traffic against the model.
    do_reset();
    for (int t = 0; t < 3000; t++) begin
      logic [3:0] p, c, e;
      p = ($urandom_range(0, 7) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'h0;
      c = ($urandom_range(0, 2) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'h0;
      e = ($urandom_range(0, 29) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      cyc("rand", 4'($urandom), 16'($urandom), ($urandom_range(0, 9) != 0), p, c, e);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
